mod_addsub_seq: RTL

- Multi-precision modular adder/subtractor for the ECC field datapath.
- Computes (a + b) mod p or (a − b) mod p on N = LIMB_W*NUM_LIMBS-bit operands. It uses one LIMB_W-bit add/sub slice iterated over limbs, least significant limb first, with the carry or borrow held in a register between cycles.
- A second limb pass computes the conditional correction by p.
- Sits between the point add/double controller and the field register file. It replaces the fixed 64-bit combinational adder/subtractor pair for wide fields.

---
 rtl/mod_addsub_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mod_addsub_seq.sv
// mod_addsub_seq
//   Multi-precision modular adder/subtractor for the ECC field datapath.
//   Computes (a + b) mod p or (a - b) mod p on N = LIMB_W*NUM_LIMBS-bit
//   operands using a single LIMB_W-bit add/sub slice iterated over the
//   limbs, least significant limb first. A first limb pass forms the raw
//   sum/difference, a second pass forms the candidate corrected by p, and
//   a final cycle picks whichever of the two is the reduced result.
//   Latency is fixed at 2*NUM_LIMBS+1 cycles from the start edge.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while busy=0
//   mode   : 0 = add, 1 = subtract (latched with start)
//   a, b   : operands, must be < p (latched with start)
//   p      : odd modulus > 1 (latched with start)
//   busy   : high while an operation is in flight
//   done   : one-cycle pulse, result valid in the same cycle
//   result : modular result, held until the next done
module mod_addsub_seq #(
  parameter int LIMB_W    = 64,
  parameter int NUM_LIMBS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   a,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   b,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   p,
  output logic                          busy,
  output logic                          done,
  output logic [LIMB_W*NUM_LIMBS-1:0]   result
);

  localparam int N     = LIMB_W * NUM_LIMBS;
  localparam int IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAW,
    CORR,
    FIN
  } state_t;

  state_t           state;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic [N-1:0]     p_reg;
  logic [N-1:0]     raw_reg;
  logic [N-1:0]     corr_reg;
  logic             mode_reg;
  logic [IDX_W-1:0] limb_idx;
  logic             c_reg;
  logic             raw_c;
  logic             corr_c;

  logic [LIMB_W-1:0] op_x;
  logic [LIMB_W-1:0] op_y;
  logic              op_sub;
  logic [LIMB_W:0]   slice;
  logic              use_corr;

  // Shared limb slice. During RAW it combines a and b in the requested
  // direction; during CORR it applies p to the raw value in the opposite
  // direction (subtract p after an add, add p back after a subtract).
  // The slice is one bit wider than a limb so its MSB is the carry or
  // borrow out; for a subtract the wrapped MSB is set exactly when the
  // true difference went negative.
  always_comb begin
    op_sub = mode_reg;
    op_x   = a_reg[limb_idx*LIMB_W +: LIMB_W];
    op_y   = b_reg[limb_idx*LIMB_W +: LIMB_W];
    if (state == CORR) begin
      op_sub = ~mode_reg;
      op_x   = raw_reg[limb_idx*LIMB_W +: LIMB_W];
      op_y   = p_reg[limb_idx*LIMB_W +: LIMB_W];
    end
    if (op_sub) begin
      slice = {1'b0, op_x} - {1'b0, op_y} - {{LIMB_W{1'b0}}, c_reg};
    end else begin
      slice = {1'b0, op_x} + {1'b0, op_y} + {{LIMB_W{1'b0}}, c_reg};
    end
  end

  // Result selection. For an add the corrected value is taken when the
  // raw sum overflowed 2^N or when subtracting p did not borrow
  // (raw >= p). For a subtract p is added back only when a < b, which
  // shows up as a borrow out of the raw pass.
  always_comb begin
    if (mode_reg) begin
      use_corr = raw_c;
    end else begin
      use_corr = raw_c | ~corr_c;
    end
  end

  // Control and datapath registers. Each RAW/CORR cycle writes one limb
  // and forwards the carry/borrow; the last limb of each pass stores its
  // out bit instead and rewinds the limb index for the next pass. Start
  // is only looked at in IDLE, so a request during an operation is
  // dropped without touching the latched operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      raw_reg  <= '0;
      corr_reg <= '0;
      mode_reg <= 1'b0;
      limb_idx <= '0;
      c_reg    <= 1'b0;
      raw_c    <= 1'b0;
      corr_c   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            p_reg    <= p;
            mode_reg <= mode;
            limb_idx <= '0;
            c_reg    <= 1'b0;
            busy     <= 1'b1;
            state    <= RAW;
          end
        end
        RAW: begin
          raw_reg[limb_idx*LIMB_W +: LIMB_W] <= slice[LIMB_W-1:0];
          if (limb_idx == LAST_IDX) begin
            raw_c    <= slice[LIMB_W];
            c_reg    <= 1'b0;
            limb_idx <= '0;
            state    <= CORR;
          end else begin
            c_reg    <= slice[LIMB_W];
            limb_idx <= limb_idx + 1'b1;
          end
        end
        CORR: begin
          corr_reg[limb_idx*LIMB_W +: LIMB_W] <= slice[LIMB_W-1:0];
          if (limb_idx == LAST_IDX) begin
            corr_c   <= slice[LIMB_W];
            c_reg    <= 1'b0;
            limb_idx <= '0;
            state    <= FIN;
          end else begin
            c_reg    <= slice[LIMB_W];
            limb_idx <= limb_idx + 1'b1;
          end
        end
        FIN: begin
          result <= use_corr ? corr_reg : raw_reg;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
